// File: rtl/mc_alu_if.sv
// mc_alu_if: request/response bundle between the datapath and the multi-cycle ALU.
//   start, opcode, A_in, B_in   : request (driven by the master)
//   busy, done, C_out, div_by_zero : response (driven by the ALU, the slave)
interface mc_alu_if #(
   parameter int W = 32
);
   logic             start;
   logic [4:0]       opcode;
   logic [W-1:0]     A_in;
   logic [W-1:0]     B_in;
   logic             busy;
   logic             done;
   logic [2*W-1:0]   C_out;
   logic             div_by_zero;

   modport master (
      output start, opcode, A_in, B_in,
      input  busy, done, C_out, div_by_zero
   );

   modport slave (
      input  start, opcode, A_in, B_in,
      output busy, done, C_out, div_by_zero
   );
endinterface

// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU. Single-cycle ops and divide-by-zero finish one
// cycle after start; MUL and DIV iterate for exactly W cycles on operand
// magnitudes and fix up the signs on the final iteration.
//   clk   : clock, rising edge
//   clear : synchronous active-high reset
//   bus   : mc_alu_if slave (start/opcode/A_in/B_in in; busy/done/C_out/div_by_zero out)
//
// state  | meaning
// S_IDLE | waiting for start; single-cycle results are written on the accept edge
// S_ITER | one shift-add (MUL) or restoring-divide (DIV) step per cycle, busy=1
// S_DONE | done=1 for one cycle, start ignored
module mc_alu #(
   parameter int W = 32
) (
   input logic     clk,
   input logic     clear,
   mc_alu_if.slave bus
);
   localparam int SW = $clog2(W);

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             neg_res_q, neg_res_d;   // product / quotient sign
   logic             neg_rem_q, neg_rem_d;   // remainder sign (dividend sign)
   logic [W-1:0]     mag_q, mag_d;           // multiplicand or divisor magnitude
   logic [W-1:0]     hi_q, hi_d;             // partial product high / running remainder
   logic [W-1:0]     lo_q, lo_d;             // multiplier shifting out / quotient shifting in
   logic [2*W-1:0]   c_q, c_d;
   logic             dbz_q, dbz_d;

   logic             accept;
   logic             iter_op;
   logic             last_iter;
   logic             b_zero;
   logic             a_neg, b_neg;
   logic [W-1:0]     a_mag, b_mag;
   logic [SW-1:0]    amt;
   logic [W-1:0]     sc_res;

   logic [W:0]       mul_sum;
   logic [W-1:0]     mul_hi, mul_lo;
   logic [2*W-1:0]   mul_prod;
   logic [W:0]       div_shift;
   logic             div_ge;
   logic [W-1:0]     div_rem, div_quo;

   assign accept    = (state_q == S_IDLE) && bus.start;
   assign b_zero    = (bus.B_in == '0);
   assign iter_op   = (bus.opcode == OP_MUL) || ((bus.opcode == OP_DIV) && !b_zero);
   assign last_iter = (cnt_q == SW'(W - 1));
   assign a_neg     = bus.A_in[W-1];
   assign b_neg     = bus.B_in[W-1];
   assign a_mag     = a_neg ? -bus.A_in : bus.A_in;
   assign b_mag     = b_neg ? -bus.B_in : bus.B_in;
   assign amt       = bus.B_in[SW-1:0];

   // state register and all datapath flops
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mag_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         c_q       <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         mag_q     <= mag_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         c_q       <= c_d;
         dbz_q     <= dbz_d;
      end
   end

   // next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (bus.start) state_d = iter_op ? S_ITER : S_DONE;
         S_ITER: if (last_iter) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // single-cycle results straight from the request operands
   always_comb begin
      sc_res = '0;
      case (bus.opcode)
         OP_ADD:  sc_res = bus.A_in + bus.B_in;
         OP_SUB:  sc_res = bus.A_in - bus.B_in;
         OP_AND:  sc_res = bus.A_in & bus.B_in;
         OP_OR:   sc_res = bus.A_in | bus.B_in;
         OP_SHR:  sc_res = bus.A_in >> amt;
         OP_SHRA: sc_res = W'($signed(bus.A_in) >>> amt);
         OP_SHL:  sc_res = bus.A_in << amt;
         // rotates via a doubled operand so amount 0 needs no special case
         OP_ROR:  sc_res = W'({bus.A_in, bus.A_in} >> amt);
         OP_ROL:  sc_res = W'(({bus.A_in, bus.A_in} << amt) >> W);
         OP_NEG:  sc_res = ~bus.B_in + 1'b1;
         OP_NOT:  sc_res = ~bus.B_in;
         default: sc_res = '0;
      endcase
   end

   // one iteration step for each algorithm, evaluated every cycle
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
      mul_hi    = mul_sum[W:1];
      mul_lo    = {mul_sum[0], lo_q[W-1:1]};
      mul_prod  = {mul_hi, mul_lo};
      div_shift = {hi_q, lo_q[W-1]};
      div_ge    = (div_shift >= {1'b0, mag_q});
      // when div_ge holds the difference is below the divisor, so W bits suffice
      div_rem   = div_ge ? (div_shift[W-1:0] - mag_q) : div_shift[W-1:0];
      div_quo   = {lo_q[W-2:0], div_ge};
   end

   // datapath next values
   always_comb begin
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      mag_d     = mag_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      c_d       = c_q;
      dbz_d     = dbz_q;
      if (accept) begin
         dbz_d     = 1'b0;
         cnt_d     = '0;
         is_div_d  = (bus.opcode == OP_DIV);
         neg_res_d = a_neg ^ b_neg;
         neg_rem_d = a_neg;
         mag_d     = (bus.opcode == OP_DIV) ? b_mag : a_mag;
         hi_d      = '0;
         lo_d      = (bus.opcode == OP_DIV) ? a_mag : b_mag;
         if (!iter_op) begin
            if (bus.opcode == OP_DIV) begin
               c_d   = {bus.A_in, {W{1'b1}}};
               dbz_d = 1'b1;
            end else begin
               c_d = {{W{1'b0}}, sc_res};
            end
         end
      end else if (state_q == S_ITER) begin
         cnt_d = cnt_q + 1'b1;
         hi_d  = is_div_q ? div_rem : mul_hi;
         lo_d  = is_div_q ? div_quo : mul_lo;
         if (last_iter) begin
            if (is_div_q)
               c_d = {neg_rem_q ? -div_rem : div_rem, neg_res_q ? -div_quo : div_quo};
            else
               c_d = neg_res_q ? -mul_prod : mul_prod;
         end
      end
   end

   // outputs
   always_comb begin
      bus.busy        = (state_q == S_ITER);
      bus.done        = (state_q == S_DONE);
      bus.C_out       = c_q;
      bus.div_by_zero = dbz_q;
   end
endmodule

// File: tb/tb_mc_alu.sv
module tb_mc_alu;
   localparam int W = 32;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] c;
      int          lat;
      logic        dbz;
   } vec_t;

   logic clk = 1'b0;
   logic clear;
   int   n_applied = 0;
   int   n_miscmp  = 0;
   vec_t vecs[$];

   mc_alu_if #(.W(W)) bus();
   mc_alu #(.W(W)) dut (.clk(clk), .clear(clear), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input vec_t v, input int idx);
      int    k;
      int    busy_bad;
      string nm;
      nm = $sformatf("vec%0d", idx);
      bus.opcode = v.op;
      bus.A_in   = v.a;
      bus.B_in   = v.b;
      bus.start  = 1'b1;
      step();
      bus.start  = 1'b0;
      bus.A_in   = $urandom;
      bus.B_in   = $urandom;
      bus.opcode = 5'($urandom);
      k = 1;
      busy_bad = 0;
      while (!bus.done && k < 100) begin
         if (bus.busy !== (v.lat > 1)) busy_bad++;
         step();
         k++;
      end
      check({nm, " latency"}, 64'(k), 64'(v.lat));
      check({nm, " C_out"}, bus.C_out, v.c);
      check({nm, " div_by_zero"}, 64'(bus.div_by_zero), 64'(v.dbz));
      check({nm, " busy pattern"}, 64'(busy_bad), 64'd0);
      check({nm, " busy at done"}, 64'(bus.busy), 64'd0);
      step();
   endtask

   initial begin
      int k;
      int done_at;
      int n_done;
      int busy_bad;

      vecs.push_back(vec_t'{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 64'h00000000_80000000, 1,  1'b0});
      vecs.push_back(vec_t'{OP_SUB,  32'h00000005, 32'h00000007, 64'h00000000_FFFFFFFE, 1,  1'b0});
      vecs.push_back(vec_t'{OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 64'h00000000_F000F000, 1,  1'b0});
      vecs.push_back(vec_t'{OP_OR,   32'h0F0F0000, 32'h000000F0, 64'h00000000_0F0F00F0, 1,  1'b0});
      vecs.push_back(vec_t'{OP_SHR,  32'h80000000, 32'h00000021, 64'h00000000_40000000, 1,  1'b0});
      vecs.push_back(vec_t'{OP_SHRA, 32'h80000000, 32'h00000004, 64'h00000000_F8000000, 1,  1'b0});
      vecs.push_back(vec_t'{OP_SHL,  32'h00000001, 32'h0000001F, 64'h00000000_80000000, 1,  1'b0});
      vecs.push_back(vec_t'{OP_ROR,  32'h00000001, 32'h00000021, 64'h00000000_80000000, 1,  1'b0});
      vecs.push_back(vec_t'{OP_ROL,  32'h80000000, 32'h00000001, 64'h00000000_00000001, 1,  1'b0});
      vecs.push_back(vec_t'{OP_ROR,  32'h12345678, 32'h00000000, 64'h00000000_12345678, 1,  1'b0});
      vecs.push_back(vec_t'{OP_ROL,  32'h12345678, 32'hFFFFFF04, 64'h00000000_23456781, 1,  1'b0});
      vecs.push_back(vec_t'{OP_NEG,  32'h0000007B, 32'h00000001, 64'h00000000_FFFFFFFF, 1,  1'b0});
      vecs.push_back(vec_t'{OP_NOT,  32'h0000007B, 32'h00000000, 64'h00000000_FFFFFFFF, 1,  1'b0});
      vecs.push_back(vec_t'{5'b00000, 32'h00000005, 32'h00000006, 64'h00000000_00000000, 1, 1'b0});
      vecs.push_back(vec_t'{OP_MUL,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 33, 1'b0});
      vecs.push_back(vec_t'{OP_MUL,  32'h00010000, 32'h00010000, 64'h00000001_00000000, 33, 1'b0});
      vecs.push_back(vec_t'{OP_MUL,  32'hFFFFFFFE, 32'hFFFFFFFD, 64'h00000000_00000006, 33, 1'b0});
      vecs.push_back(vec_t'{OP_MUL,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 33, 1'b0});
      vecs.push_back(vec_t'{OP_DIV,  32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b0});
      vecs.push_back(vec_t'{OP_DIV,  32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1'b0});
      vecs.push_back(vec_t'{OP_DIV,  32'h00000064, 32'h00000007, 64'h00000002_0000000E, 33, 1'b0});
      vecs.push_back(vec_t'{OP_DIV,  32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 33, 1'b0});
      vecs.push_back(vec_t'{OP_DIV,  32'h0000000A, 32'h00000000, 64'h0000000A_FFFFFFFF, 1,  1'b1});
      vecs.push_back(vec_t'{OP_ADD,  32'h00000001, 32'h00000002, 64'h00000000_00000003, 1,  1'b0});

      // reset state
      clear = 1'b1;
      bus.start = 1'b0;
      bus.opcode = '0;
      bus.A_in = '0;
      bus.B_in = '0;
      step();
      step();
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset C_out", bus.C_out, 64'd0);
      check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
      clear = 1'b0;
      step();

      foreach (vecs[i]) run_op(vecs[i], i);

      // MUL with a start during ITER and another during DONE, both ignored
      bus.opcode = OP_MUL;
      bus.A_in = 32'hFFFFFFFD;
      bus.B_in = 32'h00000005;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      done_at = 0;
      n_done = 0;
      busy_bad = 0;
      for (k = 1; k <= 40; k++) begin
         if (bus.done) begin
            n_done++;
            if (done_at == 0) done_at = k;
         end
         if (bus.busy !== (k >= 1 && k <= 32)) busy_bad++;
         bus.start = (k == 5) || (k == 33);
         bus.opcode = OP_ADD;
         bus.A_in = 32'd1;
         bus.B_in = 32'd2;
         step();
      end
      bus.start = 1'b0;
      check("mul_ign done cycle", 64'(done_at), 64'd33);
      check("mul_ign done count", 64'(n_done), 64'd1);
      check("mul_ign busy pattern", 64'(busy_bad), 64'd0);
      check("mul_ign C_out", bus.C_out, 64'hFFFFFFFF_FFFFFFF1);

      // clear mid-multiply, then NOT at T+12
      bus.opcode = OP_MUL;
      bus.A_in = 32'd7;
      bus.B_in = 32'd9;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      done_at = 0;
      n_done = 0;
      for (k = 1; k <= 45; k++) begin
         if (bus.done) begin
            n_done++;
            if (done_at == 0) done_at = k;
         end
         if (k == 11) begin
            check("clr busy", 64'(bus.busy), 64'd0);
            check("clr C_out", bus.C_out, 64'd0);
            check("clr done", 64'(bus.done), 64'd0);
         end
         if (k == 13) check("clr NOT C_out", bus.C_out, 64'h00000000_FFFFFFFF);
         clear = (k == 10);
         bus.start = (k == 12);
         bus.opcode = OP_NOT;
         bus.B_in = 32'd0;
         step();
      end
      bus.start = 1'b0;
      clear = 1'b0;
      check("clr done cycle", 64'(done_at), 64'd13);
      check("clr done count", 64'(n_done), 64'd1);

      // clear and start together: start dropped
      bus.opcode = OP_ADD;
      bus.A_in = 32'd1;
      bus.B_in = 32'd1;
      bus.start = 1'b1;
      clear = 1'b1;
      step();
      bus.start = 1'b0;
      clear = 1'b0;
      n_done = 0;
      for (k = 0; k < 4; k++) begin
         if (bus.done || bus.busy) n_done++;
         step();
      end
      check("clr_start activity", 64'(n_done), 64'd0);
      check("clr_start C_out", bus.C_out, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
      $finish;
   end
endmodule

// File: doc/mc_alu.md
# mc_alu

Parametrised, multi-cycle ALU for the datapath, taking over from the purely combinational unit. Single-cycle operations register their result one cycle after `start`. Multiply and divide run iteratively over exactly W cycles behind a start/busy/done handshake. Results are presented as a 2W-bit value so the datapath can split them into HI/LO as before.

## Interface
- `W`, default 32: operand width. Must be a power of two, ≥ 4. `SW = log2(W)`.
- `clk` in 1: clock; all state changes on the rising edge.
- `clear` in 1: reset. Synchronous, active-high.
- `start` in 1: operation request. Sampled only in IDLE.
- `opcode` in 5: operation select. Captured on an accepted `start`.
- `A_in` in W: operand A. Captured on an accepted `start`.
- `B_in` in W: operand B. Captured on an accepted `start`.
- `busy` out 1: high while a multiply or divide is iterating.
- `done` out 1: one-cycle pulse; `C_out` is valid from this cycle.
- `C_out` out 2W: result. Held until the next `done`.
- `div_by_zero` out 1: set with `done` for a DIV with B=0. Cleared on the next accepted `start`.

## Operation
- Opcodes:
  - ADD 00011, SUB 00100, AND 00101, OR 00110
  - SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011
  - MUL 01111, DIV 10000, NEG 10001, NOT 10010
- Any other opcode: `C_out` = 0, with the normal single-cycle `done`.
- Single-cycle ops: result is in `C_out[W-1:0]`; `C_out[2W-1:W]` = 0.
  - ADD and SUB wrap modulo 2^W.
  - NEG = ~B+1. NOT = ~B.
  - Shift and rotate amounts are `B[SW-1:0]` only, so the amount is taken modulo W. Upper bits of B are ignored.
  - SHRA replicates `A[W-1]`.
- MUL: signed two's-complement. Full 2W-bit product in `C_out`. Algorithm is free (Booth or shift-add), but it must take exactly W iteration cycles.
- DIV: signed. Quotient truncates toward zero and goes to `C_out[W-1:0]`. Remainder takes the dividend's sign and goes to `C_out[2W-1:W]`. W iteration cycles; the algorithm is free.
- DIV by zero:
  - Takes no iterations.
  - Quotient = all ones; remainder = A.
  - `div_by_zero` = 1.
- State machine:
  - IDLE: on `start`, capture the operands and opcode.
    - MUL, or DIV with B≠0 → ITER with counter = 0.
    - Otherwise compute the result → DONE.
  - ITER: `busy` = 1; counter increments each cycle. When the counter reaches W-1, write the result → DONE.
  - DONE: `done` = 1 for this cycle → IDLE.
- `start` while in ITER or DONE is ignored; no queueing.
- Operand inputs may change freely after acceptance without affecting the result.

## Timing
- Reset values: `busy`=0, `done`=0, `C_out`=0, `div_by_zero`=0. State = IDLE, counter = 0.
- `clear` overrides every state, including mid-ITER. The next cycle is IDLE with the reset values. Any in-flight result is discarded and no `done` is produced.
- `clear` and `start` in the same cycle: `clear` wins and `start` is dropped.
- Single-cycle ops and DIV-by-zero: `start` at cycle T gives `done` and a valid `C_out` at T+1.
- MUL and DIV: `start` at T gives `busy` high for T+1..T+W and `done` at T+W+1. `busy` is low during the `done` cycle.
- Back-to-back: a `start` during the `done` cycle is ignored. The earliest next accepted `start` is the cycle after `done`.
- `C_out` changes only on the `done` edge or on `clear`, never during ITER.

## Test plan
- **ADD and single-cycle latency.** W=32, ADD, A=0x7FFFFFFF, B=1, `start` at T. Required: `done` at T+1, `C_out`=0x00000000_80000000, `busy` never high.
- **Signed MUL and ignored start.** MUL, A=-3, B=5, `start` at T, then a second `start` at T+5 with ADD. Required: `busy` high T+1..T+32, `done` at T+33, `C_out`=0xFFFFFFFF_FFFFFFF1. The ADD request is ignored.
- **Signed DIV.** A=-7, B=2. Required: `done` at T+33, `C_out[31:0]`=0xFFFFFFFD (-3), `C_out[63:32]`=0xFFFFFFFF (-1), `div_by_zero`=0.
- **DIV by zero.** A=10, B=0. Required: `done` at T+1, `C_out`=0x0000000A_FFFFFFFF, `div_by_zero`=1. The next accepted ADD clears `div_by_zero`.
- **Shift and rotate amounts.**
  - ROR A=0x00000001, B=33 → `C_out`=0x00000000_80000000 (amount 1).
  - SHRA A=0x80000000, B=4 → 0xF8000000.
  - ROL A=0x80000000, B=1 → 0x00000001.
- **Clear mid-multiply.** MUL started at T, `clear` asserted at T+10. Required at T+11: `busy`=0, `C_out`=0, no `done` ever for that MUL. A NOT with B=0 started at T+12 gives `C_out`=0x00000000_FFFFFFFF at T+13.
